// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
//   Round-robin arbiter for the single write port of the 640x480 1-bit frame
//   bitmap. It grants bounded bursts of single-pixel writes to NUM_REQ
//   requesters and turns out-of-range addresses into addr_err pulses.
//
//   Optional build macro FB_ARB_VBLANK_GATE_EN: when defined, grants and beats
//   are only accepted while vblank=1. An open burst stalls, keeping its grant,
//   while vblank=0. When undefined, vblank is ignored.
//
// Ports
//   clock, reset      system clock, asynchronous active-high reset
//   req[i]            requester i wants to write; held until its burst is done
//   req_addr          flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data[i]       pixel value of requester i
//   vblank            display scan is outside the active area
//   gnt               registered one-hot grant
//   wr_en/wr_addr/wr_data  bitmap write port, one cycle after an accepted beat
//   addr_err          one-cycle pulse: accepted beat addressed beyond PIX_MAX
//   busy              a grant is open
module fb_write_arbiter #(
   parameter int NUM_REQ   = 3,
   parameter int ADDR_W    = 19,
   parameter int PIX_MAX   = 307199,
   parameter int MAX_BURST = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ-1:0]        req_data,
   input  logic                      vblank,
   output logic [NUM_REQ-1:0]        gnt,
   output logic                      wr_en,
   output logic [ADDR_W-1:0]         wr_addr,
   output logic                      wr_data,
   output logic                      addr_err,
   output logic                      busy
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_BURST) + 1;
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_GRANT = 1'b1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

   logic [0:0]        state;
   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  win;
   logic [CNT_W-1:0]  beat_cnt;
   logic [PTR_W-1:0]  nxt;
   logic              gate;
   logic              accept;
   logic              addr_bad;
   logic [ADDR_W-1:0] sel_addr;
   int                idx;

`ifdef FB_ARB_VBLANK_GATE_EN
   assign gate = vblank;
`else
   logic unused_vblank;
   assign unused_vblank = vblank;
   assign gate = 1'b1;
`endif

   // Scan downward from rr_ptr+NUM_REQ to rr_ptr+1 so the last hit, i.e. the
   // requester closest after rr_ptr, is the one that sticks.
   always_comb begin
      nxt = rr_ptr;
      idx = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (req[idx]) nxt = PTR_W'(idx);
      end
   end

   assign sel_addr = req_addr[win*ADDR_W +: ADDR_W];
   assign accept   = (state == S_GRANT) && req[win] && gate;
   assign addr_bad = sel_addr > ADDR_W'(PIX_MAX);
   assign busy     = (state == S_GRANT);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         rr_ptr   <= PTR_W'(NUM_REQ - 1);
         win      <= '0;
         beat_cnt <= '0;
         gnt      <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= 1'b0;
         addr_err <= 1'b0;
      end else begin
         // Write side runs regardless of state: the last beat of a burst is
         // written on the same edge the grant drops.
         wr_en    <= accept && !addr_bad;
         addr_err <= accept && addr_bad;
         if (accept) begin
            wr_addr <= sel_addr;
            wr_data <= req_data[win];
         end
         if (state == S_IDLE) begin
            if (|req && gate) begin
               state    <= S_GRANT;
               win      <= nxt;
               gnt      <= NUM_REQ'(1) << nxt;
               beat_cnt <= '0;
            end
         end else begin
            if (!req[win] || (accept && beat_cnt == LAST_BEAT)) begin
               state  <= S_IDLE;
               gnt    <= '0;
               rr_ptr <= win;
            end else if (accept) begin
               beat_cnt <= beat_cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_fb_write_arbiter.sv
module tb_fb_write_arbiter;
   localparam int N    = 3;
   localparam int AW   = 19;
   localparam int PMAX = 307199;

   logic clock = 1'b0;
   logic reset = 1'b1;
`ifdef FB_ARB_VBLANK_GATE_EN
   logic vblank = 1'b1;
`else
   logic vblank = 1'b0;
`endif

   // index 0: MAX_BURST=16, index 1: MAX_BURST=2
   logic [N-1:0]    req [2];
   logic [N*AW-1:0] addr [2];
   logic [N-1:0]    dat [2];
   logic [N-1:0]    gnt [2];
   logic            wr_en [2];
   logic [AW-1:0]   wr_addr [2];
   logic            wr_data [2];
   logic            addr_err [2];
   logic            busy [2];

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   fb_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .PIX_MAX(PMAX), .MAX_BURST(16)) dut16 (
      .clock(clock), .reset(reset), .req(req[0]), .req_addr(addr[0]), .req_data(dat[0]),
      .vblank(vblank), .gnt(gnt[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
      .wr_data(wr_data[0]), .addr_err(addr_err[0]), .busy(busy[0]));

   fb_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .PIX_MAX(PMAX), .MAX_BURST(2)) dut2 (
      .clock(clock), .reset(reset), .req(req[1]), .req_addr(addr[1]), .req_data(dat[1]),
      .vblank(vblank), .gnt(gnt[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
      .wr_data(wr_data[1]), .addr_err(addr_err[1]), .busy(busy[1]));

   task automatic chk(input string nm, input int p, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %0h want %0h at %0t", nm, p, act, exp, $time);
      end
   endtask

   function automatic logic gate_f();
`ifdef FB_ARB_VBLANK_GATE_EN
      return vblank;
`else
      return 1'b1;
`endif
   endfunction

   // ---------------- requesters: list of beats, advance after each accept
   int rq_left [2][N];
   int rq_addr [2][N];
   int rq_step [2][N];

   task automatic drive();
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < N; i++) begin
            req[p][i]            = rq_left[p][i] > 0;
            addr[p][i*AW +: AW]  = rq_addr[p][i][AW-1:0];
            dat[p][i]            = rq_addr[p][i][0];
         end
   endtask

   task automatic start(input int p, input int i, input int a, input int s, input int n);
      rq_addr[p][i] = a;
      rq_step[p][i] = s;
      rq_left[p][i] = n;
      drive();
   endtask

   task automatic stop_all();
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < N; i++) rq_left[p][i] = 0;
      drive();
   endtask

   initial begin
      logic acc [2][N];
      forever begin
         @(posedge clock);
         for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++)
               acc[p][i] = !reset && gnt[p][i] && req[p][i] && gate_f();
         #1;
         for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++)
               if (acc[p][i] && rq_left[p][i] > 0) begin
                  rq_left[p][i]--;
                  rq_addr[p][i] += rq_step[p][i];
               end
         drive();
      end
   end

   // ---------------- behavioural model: owner / beats taken / last owner
   int            m_owner [2] = '{-1, -1};
   int            m_beats [2] = '{0, 0};
   int            m_last  [2] = '{N-1, N-1};
   logic [N-1:0]  e_gnt [2]     = '{'0, '0};
   logic          e_wr_en [2]   = '{1'b0, 1'b0};
   logic [AW-1:0] e_wr_addr [2] = '{'0, '0};
   logic          e_wr_data [2] = '{1'b0, 1'b0};
   logic          e_err [2]     = '{1'b0, 1'b0};

   task automatic model_step(input int p);
      int o, mb, c;
      logic a, g, found;
      logic [AW-1:0] ad;
      mb = (p == 0) ? 16 : 2;
      o  = m_owner[p];
      g  = gate_f();
      a  = 1'b0;
      ad = '0;
      if (o >= 0) begin
         a  = req[p][o] && g;
         ad = addr[p][o*AW +: AW];
      end
      e_wr_en[p] = a && (ad <= PMAX);
      e_err[p]   = a && (ad > PMAX);
      if (a) begin
         e_wr_addr[p] = ad;
         e_wr_data[p] = dat[p][o];
      end
      if (o < 0) begin
         found = 1'b0;
         if (req[p] != 0 && g)
            for (int k = 1; k <= N; k++) begin
               c = (m_last[p] + k) % N;
               if (!found && req[p][c]) begin
                  found      = 1'b1;
                  m_owner[p] = c;
                  m_beats[p] = 0;
               end
            end
      end else begin
         if (a) m_beats[p]++;
         if (!req[p][o] || m_beats[p] == mb) begin
            m_last[p]  = o;
            m_owner[p] = -1;
         end
      end
      e_gnt[p] = (m_owner[p] >= 0) ? N'(1) << m_owner[p] : '0;
   endtask

   initial forever begin
      @(posedge clock or posedge reset);
      for (int p = 0; p < 2; p++)
         if (reset) begin
            m_owner[p] = -1; m_beats[p] = 0; m_last[p] = N-1;
            e_gnt[p] = '0; e_wr_en[p] = 1'b0; e_wr_addr[p] = '0;
            e_wr_data[p] = 1'b0; e_err[p] = 1'b0;
         end else model_step(p);
   end

   // ---------------- compare every cycle + event logs for literal checks
   logic [AW-1:0] wlog [$];
   logic [N-1:0]  gtrace [$];
   int            err_cnt = 0;
   logic          trace_on = 1'b0;

   initial forever begin
      @(negedge clock);
      for (int p = 0; p < 2; p++) begin
         chk("gnt", p, 32'(gnt[p]), 32'(e_gnt[p]));
         chk("busy", p, 32'(busy[p]), 32'(e_gnt[p] != 0));
         chk("wr_en", p, 32'(wr_en[p]), 32'(e_wr_en[p]));
         chk("wr_addr", p, 32'(wr_addr[p]), 32'(e_wr_addr[p]));
         chk("wr_data", p, 32'(wr_data[p]), 32'(e_wr_data[p]));
         chk("addr_err", p, 32'(addr_err[p]), 32'(e_err[p]));
      end
      if (wr_en[0]) wlog.push_back(wr_addr[0]);
      if (addr_err[0]) err_cnt++;
      if (trace_on) gtrace.push_back(gnt[1]);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [N-1:0] exp_tr [11];
      int n;
      exp_tr = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010,
                 3'b000, 3'b100, 3'b100, 3'b000, 3'b001};
      stop_all();
      tick(2);
      reset = 1'b0;
      tick(1);
      chk("rst_gnt", 0, 32'(gnt[0]), 0);
      chk("rst_busy", 0, 32'(busy[0]), 0);
      chk("rst_wr_en", 1, 32'(wr_en[1]), 0);

      // 1: four-beat burst from requester 0
      wlog.delete();
      start(0, 0, 100, 1, 4);
      tick(1);
      chk("s1_gnt", 0, 32'(gnt[0]), 32'b001);
      tick(6);
      chk("s1_nwr", 0, wlog.size(), 4);
      for (int k = 0; k < 4 && k < wlog.size(); k++) chk("s1_addr", k, 32'(wlog[k]), 100 + k);
      chk("s1_gnt_off", 0, 32'(gnt[0]), 0);

      // 2: all three requesting, MAX_BURST=2
      gtrace.delete();
      trace_on = 1'b1;
      start(1, 0, 10, 1, 100);
      start(1, 1, 20, 1, 100);
      start(1, 2, 30, 1, 100);
      tick(11);
      trace_on = 1'b0;
      stop_all();
      chk("s2_len", 1, gtrace.size(), 11);
      for (int k = 0; k < 11 && k < gtrace.size(); k++) chk("s2_trace", k, 32'(gtrace[k]), 32'(exp_tr[k]));
      tick(3);

      // 3: out-of-range then last legal pixel
      wlog.delete();
      err_cnt = 0;
      start(0, 1, 307200, -1, 2);
      tick(6);
      chk("s3_err", 0, err_cnt, 1);
      chk("s3_nwr", 0, wlog.size(), 1);
      if (wlog.size() > 0) chk("s3_addr", 0, 32'(wlog[0]), 307199);

      // 4: reset in the middle of an 8-beat burst
      wlog.delete();
      start(0, 0, 200, 1, 8);
      n = 0;
      while (wlog.size() < 3 && n < 30) begin
         @(negedge clock);
         #1;
         n++;
      end
      chk("s4_reach", 0, 32'(wlog.size() >= 3), 1);
      reset = 1'b1;
      stop_all();
      #1;
      chk("s4_gnt", 0, 32'(gnt[0]), 0);
      chk("s4_wr_en", 0, 32'(wr_en[0]), 0);
      chk("s4_wr_addr", 0, 32'(wr_addr[0]), 0);
      chk("s4_busy", 0, 32'(busy[0]), 0);
      chk("s4_err", 0, 32'(addr_err[0]), 0);
      chk("s4_data", 0, 32'(wr_data[0]), 0);
      tick(2);
      reset = 1'b0;
      start(0, 0, 300, 1, 2);
      start(0, 1, 400, 1, 2);
      tick(1);
      chk("s4_first", 0, 32'(gnt[0]), 32'b001);
      tick(10);

`ifdef FB_ARB_VBLANK_GATE_EN
      // 5: grants and beats confined to vblank
      vblank = 1'b0;
      wlog.delete();
      start(0, 2, 500, 1, 6);
      tick(3);
      chk("s5_nogrant", 0, 32'(gnt[0]), 0);
      vblank = 1'b1;
      tick(1);
      chk("s5_gnt", 0, 32'(gnt[0]), 32'b100);
      tick(2);
      vblank = 1'b0;
      tick(1);
      chk("s5_stall_wr", 0, 32'(wr_en[0]), 0);
      chk("s5_stall_gnt", 0, 32'(gnt[0]), 32'b100);
      tick(2);
      chk("s5_frozen", 0, wlog.size(), 2);
      vblank = 1'b1;
      tick(10);
      chk("s5_nwr", 0, wlog.size(), 6);
      if (wlog.size() == 6) chk("s5_last", 0, 32'(wlog[5]), 505);
      chk("s5_gnt_off", 0, 32'(gnt[0]), 0);
`else
      // 6: vblank ignored
      vblank = 1'b0;
      wlog.delete();
      start(0, 2, 500, 1, 4);
      tick(1);
      chk("s6_gnt", 0, 32'(gnt[0]), 32'b100);
      tick(6);
      chk("s6_nwr", 0, wlog.size(), 4);
      if (wlog.size() == 4) chk("s6_last", 0, 32'(wlog[3]), 503);
      chk("s6_gnt_off", 0, 32'(gnt[0]), 0);
`endif
      tick(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
